// File: rtl/btn_trigger_gen.sv
// Button front end: 2-flop sync, debounce FSM, single-cycle trigger and long-press pulses.
// Trigger rises DEBOUNCE_CYCLES+1 edges after btn_in is first sampled high; a press accepted while busy is dropped and counted.
module btn_trigger_gen #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned LONG_PRESS_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_in,
  input  logic       busy,
  output logic       trig_pulse,
  output logic       long_pulse,
  output logic       btn_level,
  output logic [7:0] drop_cnt
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [7:0]        DROP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_btn_s;
  state_t            r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_fired;
  logic              r_trig;
  logic              r_long;
  logic              r_level;
  logic [7:0]        r_drop_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_db_cnt     <= '0;
      r_hold_cnt   <= '0;
      r_long_fired <= 1'b0;
      r_trig       <= 1'b0;
      r_long       <= 1'b0;
      r_level      <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_trig <= 1'b0;
      r_long <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_btn_s) begin
            r_state  <= DB_PRESS;
            r_db_cnt <= DB_ONE;
          end
        end

        DB_PRESS: begin
          if (!w_btn_s) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            r_state    <= PRESSED;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b1;
            // busy only matters on this acceptance edge
            if (busy) begin
              if (r_drop_cnt != DROP_MAX) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
              end
            end else begin
              r_trig <= 1'b1;
            end
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end

        PRESSED: begin
          // Hold counter parks at its last value so it can never wrap into a second long pulse
          if (r_hold_cnt == HOLD_LAST) begin
            if (!r_long_fired) begin
              r_long       <= 1'b1;
              r_long_fired <= 1'b1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          end
          if (!w_btn_s) begin
            r_state  <= DB_RELEASE;
            r_db_cnt <= DB_ONE;
          end
        end

        DB_RELEASE: begin
          if (w_btn_s) begin
            r_state  <= PRESSED;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            r_state      <= IDLE;
            r_db_cnt     <= '0;
            r_level      <= 1'b0;
            r_long_fired <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_db_cnt <= '0;
          r_level  <= 1'b0;
        end
      endcase
    end
  end

  assign trig_pulse = r_trig;
  assign long_pulse = r_long;
  assign btn_level  = r_level;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_btn_trigger_gen.sv
// Directed bench for btn_trigger_gen at default parameters: vector table plus reset, latency, long-press and saturation sequences.
module tb_btn_trigger_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_in;
  logic       busy;
  logic       trig_pulse;
  logic       long_pulse;
  logic       btn_level;
  logic [7:0] drop_cnt;

  btn_trigger_gen dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn_in     (btn_in),
    .busy       (busy),
    .trig_pulse (trig_pulse),
    .long_pulse (long_pulse),
    .btn_level  (btn_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int   tests     = 0;
  int   fails     = 0;
  int   n_trig    = 0;
  int   n_long    = 0;
  int   n_overlap = 0;
  int   n_dbl     = 0;
  logic prev_trig = 1'b0;
  logic prev_long = 1'b0;

  typedef struct {
    string name;
    logic  btn;
    logic  bsy;
    int    cycles;
    int    exp_trig;
    int    exp_long;
    int    exp_level;
    int    exp_drop;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (trig_pulse) n_trig++;
    if (long_pulse) n_long++;
    if (trig_pulse && long_pulse) n_overlap++;
    if ((trig_pulse && prev_trig) || (long_pulse && prev_long)) n_dbl++;
    prev_trig = trig_pulse;
    prev_long = long_pulse;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int t0, l0, first_trig, first_long, first_low;

    vecs[0]  = '{"idle",        1'b0, 1'b0,   20, 0, 0, 0, 0};
    vecs[1]  = '{"bounce_hi",   1'b1, 1'b0,   10, 0, 0, 0, 0};
    vecs[2]  = '{"bounce_lo",   1'b0, 1'b0,   20, 0, 0, 0, 0};
    vecs[3]  = '{"press",       1'b1, 1'b0,   30, 1, 0, 1, 0};
    vecs[4]  = '{"hold_long",   1'b1, 1'b0, 1100, 0, 1, 1, 0};
    vecs[5]  = '{"glitch_lo",   1'b0, 1'b0,    5, 0, 0, 1, 0};
    vecs[6]  = '{"glitch_hi",   1'b1, 1'b0,   50, 0, 0, 1, 0};
    vecs[7]  = '{"release",     1'b0, 1'b0,   30, 0, 0, 0, 0};
    vecs[8]  = '{"busy_press",  1'b1, 1'b1,   30, 0, 0, 1, 1};
    vecs[9]  = '{"busy_rel",    1'b0, 1'b1,   30, 0, 0, 0, 1};
    vecs[10] = '{"busy_press2", 1'b1, 1'b1,   30, 0, 0, 1, 2};
    vecs[11] = '{"busy_clear",  1'b1, 1'b0,   20, 0, 0, 1, 2};
    vecs[12] = '{"release2",    1'b0, 1'b0,   30, 0, 0, 0, 2};
    vecs[13] = '{"short_press", 1'b1, 1'b0,  100, 1, 0, 1, 2};
    vecs[14] = '{"short_rel",   1'b0, 1'b0,   30, 0, 0, 0, 2};

    rstn   = 1'b0;
    btn_in = 1'b0;
    busy   = 1'b0;
    run(3);
    check("reset_trig",  int'(trig_pulse), 0);
    check("reset_long",  int'(long_pulse), 0);
    check("reset_level", int'(btn_level), 0);
    check("reset_drop",  int'(drop_cnt), 0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      btn_in = vecs[i].btn;
      busy   = vecs[i].bsy;
      t0 = n_trig;
      l0 = n_long;
      run(vecs[i].cycles);
      check({vecs[i].name, "_trig"},  n_trig - t0, vecs[i].exp_trig);
      check({vecs[i].name, "_long"},  n_long - l0, vecs[i].exp_long);
      check({vecs[i].name, "_level"}, int'(btn_level), vecs[i].exp_level);
      check({vecs[i].name, "_drop"},  int'(drop_cnt), vecs[i].exp_drop);
    end

    // Reset in the middle of a press debounce, with drop_cnt non-zero
    btn_in = 1'b1;
    run(8);
    rstn = 1'b0;
    #1;
    check("rst_dbp_trig",  int'(trig_pulse), 0);
    check("rst_dbp_level", int'(btn_level), 0);
    check("rst_dbp_drop",  int'(drop_cnt), 0);
    btn_in = 1'b0;
    run(3);
    rstn = 1'b1;

    // Reset in the middle of a hold, then release reset with the button still down
    btn_in = 1'b1;
    run(40);
    check("pre_rst_level", int'(btn_level), 1);
    rstn = 1'b0;
    #1;
    check("rst_prs_level", int'(btn_level), 0);
    check("rst_prs_trig",  int'(trig_pulse), 0);
    check("rst_prs_long",  int'(long_pulse), 0);
    run(3);
    rstn = 1'b1;
    t0 = n_trig;
    first_trig = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (trig_pulse && first_trig < 0) first_trig = k;
    end
    check("post_rst_latency", first_trig, 18);
    check("post_rst_ntrig",   n_trig - t0, 1);

    // Bounce then exact edge-by-edge press latency
    btn_in = 1'b0;
    run(40);
    btn_in = 1'b1;
    run(10);
    btn_in = 1'b0;
    t0 = n_trig;
    run(20);
    check("bounce2_trig",  n_trig - t0, 0);
    check("bounce2_level", int'(btn_level), 0);
    btn_in = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check($sformatf("lat_trig_%0d", k),  int'(trig_pulse), (k == 18) ? 1 : 0);
      check($sformatf("lat_level_%0d", k), int'(btn_level),  (k >= 18) ? 1 : 0);
    end

    // Long press: trigger, one long pulse 1024 edges later, then release timing
    btn_in = 1'b0;
    run(40);
    btn_in = 1'b1;
    t0 = n_trig;
    l0 = n_long;
    first_trig = -1;
    first_long = -1;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (trig_pulse && first_trig < 0) first_trig = k;
      if (long_pulse && first_long < 0) first_long = k;
    end
    check("long_trig_at",  first_trig, 18);
    check("long_pulse_at", first_long, 18 + 1024);
    check("long_ntrig",    n_trig - t0, 1);
    check("long_nlong",    n_long - l0, 1);
    btn_in = 1'b0;
    first_low = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!btn_level && first_low < 0) first_low = k;
    end
    check("release_at",   first_low, 18);
    check("release_long", n_long - l0, 1);

    // Busy presses: counted, never triggered, saturating at 255
    busy = 1'b1;
    t0 = n_trig;
    for (int p = 0; p < 300; p++) begin
      btn_in = 1'b1;
      run(25);
      btn_in = 1'b0;
      run(25);
      if (p == 0) check("drop_first", int'(drop_cnt), 1);
    end
    check("drop_sat",       int'(drop_cnt), 255);
    check("drop_no_trig",   n_trig - t0, 0);
    check("pulse_overlap",  n_overlap, 0);
    check("pulse_double",   n_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
